// File: rtl/rf_pkg.sv
// rf_pkg: register-file widths, address/data types and a wrap-around index helper.
package rf_pkg;
   localparam int XLEN = 64;
   localparam int AW = 5;
   localparam int NUM_REGS = 32;
   typedef logic [AW-1:0] reg_addr_t;
   typedef logic [XLEN-1:0] xlen_t;
   function automatic int wrap_inc(input int i, input int n);
      return (i == n - 1) ? 0 : i + 1;
   endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching req upward from ptr with wrap.
module rr_arbiter #(
   parameter int N = 3,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx
);
   int j;
   // Walk from farthest to nearest so the candidate closest to ptr is written last and wins.
   always_comb begin
      grant = '0;
      idx = '0;
      j = 0;
      for (int k = N - 1; k >= 0; k--) begin
         j = (int'(ptr) + k) % N;
         if (req[j]) begin
            grant = '0;
            grant[j] = 1'b1;
            idx = IW'(j);
         end
      end
   end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin writeback port sharing, registered RF write stage and RAW scoreboard.
// Optional per-requester grant counters on output grant_cnt when RF_WB_ARB_STATS_EN is defined.
module regfile_wb_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int XLEN = rf_pkg::XLEN,
   parameter int AW = rf_pkg::AW
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_REQ-1:0]      req_valid,
   input  logic [NUM_REQ*AW-1:0]   req_rd,
   input  logic [NUM_REQ*XLEN-1:0] req_data,
   output logic [NUM_REQ-1:0]      req_ready,
   input  logic                    alloc_valid,
   input  logic [AW-1:0]           alloc_rd,
   input  logic                    flush,
   output logic [31:0]             pending,
   output logic                    wr_en,
   output logic [AW-1:0]           wr_addr,
   output logic [XLEN-1:0]         wr_data
`ifdef RF_WB_ARB_STATS_EN
   ,
   output logic [NUM_REQ*32-1:0]   grant_cnt
`endif
);
   import rf_pkg::*;
   localparam int IW = $clog2(NUM_REQ);
   logic [NUM_REQ-1:0] grant;
   logic [IW-1:0] g_idx, rr_ptr_q, rr_ptr_d;
   logic hs, wr_en_q, wr_en_d;
   logic [AW-1:0] g_rd, wr_addr_q, wr_addr_d;
   logic [XLEN-1:0] g_data, wr_data_q, wr_data_d;
   logic [NUM_REGS-1:0] pending_q, pending_d;

   rr_arbiter #(.N(NUM_REQ)) u_arb (
      .req   (req_valid),
      .ptr   (rr_ptr_q),
      .grant (grant),
      .idx   (g_idx)
   );

   assign req_ready = grant;
   assign wr_en = wr_en_q;
   assign wr_addr = wr_addr_q;
   assign wr_data = wr_data_q;
   assign pending = pending_q;

   // Commit-clear first, then newer allocation wins, then flush wipes everything.
   always_comb begin
      hs = |grant;
      g_rd = req_rd[g_idx*AW +: AW];
      g_data = req_data[g_idx*XLEN +: XLEN];
      rr_ptr_d = hs ? IW'(wrap_inc(int'(g_idx), NUM_REQ)) : rr_ptr_q;
      wr_en_d = hs && (g_rd != '0);
      wr_addr_d = hs ? g_rd : wr_addr_q;
      wr_data_d = hs ? g_data : wr_data_q;
      pending_d = pending_q;
      if (wr_en_q && wr_addr_q != '0) pending_d[wr_addr_q] = 1'b0;
      if (alloc_valid && alloc_rd != '0) pending_d[alloc_rd] = 1'b1;
      if (flush) pending_d = '0;
      pending_d[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr_q <= '0;
         wr_en_q <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         pending_q <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         wr_en_q <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         pending_q <= pending_d;
      end
   end

`ifdef RF_WB_ARB_STATS_EN
   logic [NUM_REQ*32-1:0] grant_cnt_q, grant_cnt_d;
   assign grant_cnt = grant_cnt_q;
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++)
         grant_cnt_d[i*32 +: 32] = grant_cnt_q[i*32 +: 32] + 32'(grant[i]);
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) grant_cnt_q <= '0;
      else grant_cnt_q <= grant_cnt_d;
   end
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: table-driven vectors plus hand sequences for reset, fairness and stats.
module tb_regfile_wb_arbiter;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [2:0] req_valid = '0;
   logic [14:0] req_rd = '0;
   logic [191:0] req_data = '0;
   logic [2:0] req_ready;
   logic alloc_valid = 1'b0;
   logic [4:0] alloc_rd = '0;
   logic flush = 1'b0;
   logic [31:0] pending;
   logic wr_en;
   logic [4:0] wr_addr;
   logic [63:0] wr_data;
`ifdef RF_WB_ARB_STATS_EN
   logic [95:0] grant_cnt;
`endif
   int n_checks = 0;
   int n_fail = 0;

   regfile_wb_arbiter dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_rd      (req_rd),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .alloc_valid (alloc_valid),
      .alloc_rd    (alloc_rd),
      .flush       (flush),
      .pending     (pending),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data)
`ifdef RF_WB_ARB_STATS_EN
      ,
      .grant_cnt   (grant_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  valid;
      logic [4:0]  rd0, rd1, rd2;
      logic        alloc;
      logic [4:0]  ard;
      logic        fl;
      logic [2:0]  ready;
      logic        wen;
      logic [4:0]  addr;
      logic [63:0] data;
      logic [31:0] pend;
   } vec_t;

   vec_t v[18];

   function automatic vec_t mk(input logic [2:0] valid, input logic [4:0] rd0, rd1, rd2,
                               input logic alloc, input logic [4:0] ard, input logic fl,
                               input logic [2:0] ready, input logic wen, input logic [4:0] addr,
                               input logic [63:0] data, input logic [31:0] pend);
      vec_t r;
      r.valid = valid; r.rd0 = rd0; r.rd1 = rd1; r.rd2 = rd2;
      r.alloc = alloc; r.ard = ard; r.fl = fl;
      r.ready = ready; r.wen = wen; r.addr = addr; r.data = data; r.pend = pend;
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [2:0] valid, input logic [4:0] rd0, rd1, rd2);
      req_valid = valid;
      req_rd = {rd2, rd1, rd0};
      req_data = {32'hCAFE0002, 27'b0, rd2, 32'hCAFE0001, 27'b0, rd1, 32'hCAFE0000, 27'b0, rd0};
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      v[0]  = mk(3'b001, 5, 6, 7, 0, 0, 0, 3'b001, 1, 5, 64'hCAFE0000_00000005, 0);
      v[1]  = mk(3'b000, 5, 6, 7, 0, 0, 0, 3'b000, 0, 5, 64'hCAFE0000_00000005, 0);
      v[2]  = mk(3'b111, 5, 6, 7, 0, 0, 0, 3'b010, 1, 6, 64'hCAFE0001_00000006, 0);
      v[3]  = mk(3'b111, 5, 6, 7, 0, 0, 0, 3'b100, 1, 7, 64'hCAFE0002_00000007, 0);
      v[4]  = mk(3'b111, 5, 6, 7, 0, 0, 0, 3'b001, 1, 5, 64'hCAFE0000_00000005, 0);
      v[5]  = mk(3'b101, 5, 6, 7, 0, 0, 0, 3'b100, 1, 7, 64'hCAFE0002_00000007, 0);
      v[6]  = mk(3'b101, 5, 6, 7, 0, 0, 0, 3'b001, 1, 5, 64'hCAFE0000_00000005, 0);
      v[7]  = mk(3'b010, 5, 0, 7, 0, 0, 0, 3'b010, 0, 0, 64'hCAFE0001_00000000, 0);
      v[8]  = mk(3'b000, 5, 6, 7, 1, 7, 0, 3'b000, 0, 0, 64'hCAFE0001_00000000, 32'h80);
      v[9]  = mk(3'b100, 5, 6, 7, 0, 0, 0, 3'b100, 1, 7, 64'hCAFE0002_00000007, 32'h80);
      v[10] = mk(3'b000, 5, 6, 7, 0, 0, 0, 3'b000, 0, 7, 64'hCAFE0002_00000007, 0);
      v[11] = mk(3'b001, 7, 6, 7, 0, 0, 0, 3'b001, 1, 7, 64'hCAFE0000_00000007, 0);
      v[12] = mk(3'b000, 5, 6, 7, 1, 7, 0, 3'b000, 0, 7, 64'hCAFE0000_00000007, 32'h80);
      v[13] = mk(3'b000, 5, 6, 7, 1, 3, 0, 3'b000, 0, 7, 64'hCAFE0000_00000007, 32'h88);
      v[14] = mk(3'b000, 5, 6, 7, 1, 3, 1, 3'b000, 0, 7, 64'hCAFE0000_00000007, 0);
      v[15] = mk(3'b000, 5, 6, 7, 1, 0, 0, 3'b000, 0, 7, 64'hCAFE0000_00000007, 0);
      v[16] = mk(3'b010, 5, 9, 7, 1, 9, 1, 3'b010, 1, 9, 64'hCAFE0001_00000009, 0);
      v[17] = mk(3'b000, 5, 6, 7, 0, 0, 0, 3'b000, 0, 9, 64'hCAFE0001_00000009, 0);

      drive(3'b000, 0, 0, 0);
      tick();
      tick();
      reset = 1'b0;
      check("reset_wr_en", 64'(wr_en), 0);
      check("reset_wr_addr", 64'(wr_addr), 0);
      check("reset_wr_data", wr_data, 0);
      check("reset_pending", 64'(pending), 0);
      check("reset_ready", 64'(req_ready), 0);

      for (int i = 0; i < 18; i++) begin
         drive(v[i].valid, v[i].rd0, v[i].rd1, v[i].rd2);
         alloc_valid = v[i].alloc;
         alloc_rd = v[i].ard;
         flush = v[i].fl;
         #1;
         check($sformatf("v%0d_ready", i), 64'(req_ready), 64'(v[i].ready));
         tick();
         check($sformatf("v%0d_wr_en", i), 64'(wr_en), 64'(v[i].wen));
         check($sformatf("v%0d_wr_addr", i), 64'(wr_addr), 64'(v[i].addr));
         check($sformatf("v%0d_wr_data", i), wr_data, v[i].data);
         check($sformatf("v%0d_pending", i), 64'(pending), 64'(v[i].pend));
      end
      alloc_valid = 1'b0;
      flush = 1'b0;

      // Asynchronous reset drops a write held in the output stage.
      drive(3'b111, 5, 6, 12);
      alloc_valid = 1'b1;
      alloc_rd = 5'd4;
      tick();
      alloc_valid = 1'b0;
      check("pre_reset_wr_en", 64'(wr_en), 1);
      check("pre_reset_pending", 64'(pending), 32'h10);
      drive(3'b000, 0, 0, 0);
      #2 reset = 1'b1;
      #1;
      check("async_reset_wr_en", 64'(wr_en), 0);
      check("async_reset_wr_addr", 64'(wr_addr), 0);
      check("async_reset_pending", 64'(pending), 0);
      tick();
      reset = 1'b0;

      for (int k = 0; k < 6; k++) begin
         drive(3'b111, 5, 6, 7);
         #1;
         check($sformatf("fair%0d_ready", k), 64'(req_ready), 64'(3'b001 << (k % 3)));
         tick();
      end
      drive(3'b000, 0, 0, 0);

`ifdef RF_WB_ARB_STATS_EN
      #2 reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         drive(3'b010, 5, (k == 2) ? 5'd0 : 5'd8, 7);
         tick();
      end
      drive(3'b000, 0, 0, 0);
      tick();
      check("stats_cnt0", 64'(grant_cnt[31:0]), 0);
      check("stats_cnt1", 64'(grant_cnt[63:32]), 4);
      check("stats_cnt2", 64'(grant_cnt[95:64]), 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
